// File: rtl/para_pkg.sv
// Purpose: shared types and constants for the parameter frame transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package para_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int FRAME_LEN = 6;
    localparam int IDX_W     = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [7:0] HEADER_DEF  = 8'hA5;
    localparam logic [7:0] PARA_ID_DEF = 8'h01;

endpackage

// File: rtl/para_send_if.sv
// Purpose: byte-wide valid/ready stream toward the host uplink.
// Latency: n/a (wires only).
// Backpressure: a byte moves only when tx_vld and tx_rdy are both high.
interface para_send_if;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy;

    modport master (output tx_data, output tx_vld, input tx_rdy);
    modport slave  (input tx_data, input tx_vld, output tx_rdy);
endinterface

// File: rtl/para_frame_mux.sv
// Purpose: selects one frame byte by index (header/id/seq/payload hi/lo/chk).
// Latency: combinational.
// Backpressure: none; the caller decides when the index advances.
module para_frame_mux
    import para_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic [7:0]       header_i,
    input  logic [7:0]       id_i,
    input  logic [7:0]       seq_i,
    input  logic [15:0]      payload_i,
    input  logic [7:0]       chk_i,
    output logic [7:0]       byte_o
);

    // Byte select in frame order; out-of-range indices read as zero.
    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            3'd0:    byte_o = header_i;
            3'd1:    byte_o = id_i;
            3'd2:    byte_o = seq_i;
            3'd3:    byte_o = payload_i[15:8];
            3'd4:    byte_o = payload_i[7:0];
            3'd5:    byte_o = chk_i;
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/para_send.sv
// Purpose: snapshots sta_para_ave on para_upd and sends it as a 6-byte checksummed frame.
// Latency: header presented the cycle after the strobe; back-to-back frames have no gap.
// Backpressure: tx_data/tx_vld hold until tx_rdy; one pending slot, overwrites counted in drop_cnt.
module para_send
    import para_pkg::*;
#(
    parameter logic [7:0] HEADER  = HEADER_DEF,
    parameter logic [7:0] PARA_ID = PARA_ID_DEF
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic [15:0]         sta_para_ave,
    input  logic                para_upd,
    para_send_if.master         tx,
    output logic                frame_busy,
    output logic [7:0]          drop_cnt
);

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [15:0]       frame_q;
    logic [15:0]       pend_val_q;
    logic              pend_q;
    logic [7:0]        seq_q;
    logic [7:0]        chk_q;
    logic [7:0]        drop_cnt_q;
    logic [7:0]        tx_data_q;
    logic              tx_vld_q;

    logic              fire;
    logic [IDX_W-1:0]  idx_d;
    logic [7:0]        chk_d;
    logic [7:0]        drop_cnt_d;
    logic [7:0]        byte_d;

    // Next byte index, running checksum (header excluded) and saturating drop count.
    always_comb begin
        fire       = tx_vld_q & tx.tx_rdy;
        idx_d      = idx_q + 1'b1;
        chk_d      = (idx_q != '0) ? (chk_q + tx_data_q) : chk_q;
        drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : (drop_cnt_q + 8'h01);
    end

    // The byte after the one being accepted, so tx_data can be registered.
    para_frame_mux u_mux (
        .idx_i     (idx_d),
        .header_i  (HEADER),
        .id_i      (PARA_ID),
        .seq_i     (seq_q),
        .payload_i (frame_q),
        .chk_i     (chk_d),
        .byte_o    (byte_d)
    );

    // Frame FSM with pending slot; all outputs come straight from these registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            seq_q      <= '0;
            chk_q      <= '0;
            drop_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (para_upd) begin
                        frame_q   <= sta_para_ave;
                        idx_q     <= '0;
                        chk_q     <= '0;
                        tx_data_q <= HEADER;
                        tx_vld_q  <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (fire && idx_q == LAST_IDX) begin
                        seq_q <= seq_q + 8'h01;
                        idx_q <= '0;
                        chk_q <= '0;
                        if (para_upd || pend_q) begin
                            // A strobe on the last byte is the newest value and wins
                            // over anything already waiting.
                            frame_q   <= para_upd ? sta_para_ave : pend_val_q;
                            pend_q    <= 1'b0;
                            tx_data_q <= HEADER;
                            if (para_upd && pend_q) begin
                                drop_cnt_q <= drop_cnt_d;
                            end
                        end else begin
                            tx_vld_q  <= 1'b0;
                            tx_data_q <= '0;
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        if (fire) begin
                            idx_q     <= idx_d;
                            chk_q     <= chk_d;
                            tx_data_q <= byte_d;
                        end
                        if (para_upd) begin
                            pend_val_q <= sta_para_ave;
                            pend_q     <= 1'b1;
                            if (pend_q) begin
                                drop_cnt_q <= drop_cnt_d;
                            end
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tx_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx.tx_data = tx_data_q;
    assign tx.tx_vld  = tx_vld_q;
    assign frame_busy = (state_q == ST_SEND);
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_para_send.sv
// Purpose: randomized and directed bench for para_send against a frame-level model.
// Latency: checks header one cycle after the strobe and zero-gap back-to-back frames.
// Backpressure: random tx_rdy stalls; model demands the presented byte hold while stalled.
module tb_para_send;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] sta_para_ave = '0;
    logic        para_upd = 1'b0;
    logic        frame_busy;
    logic [7:0]  drop_cnt;

    para_send_if tx_if ();

    para_send dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .sta_para_ave (sta_para_ave),
        .para_upd     (para_upd),
        .tx           (tx_if),
        .frame_busy   (frame_busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int zero_seq_frames = 0;

    logic [7:0] log_b[$];
    int         log_t[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0]  m_frame[6];
    int          m_pos;
    bit          m_busy;
    bit          m_pend;
    logic [15:0] m_pval;
    logic [7:0]  m_seq;
    logic [7:0]  m_drop;

    function automatic void build(input logic [7:0] s, input logic [15:0] a);
        int sum;
        sum = 8'h01 + s + a[15:8] + a[7:0];
        m_frame[0] = 8'hA5;
        m_frame[1] = 8'h01;
        m_frame[2] = s;
        m_frame[3] = a[15:8];
        m_frame[4] = a[7:0];
        m_frame[5] = sum[7:0];
        m_pos  = 0;
        m_busy = 1'b1;
    endfunction

    function automatic void note_drop();
        if (m_drop != 8'hFF) m_drop = m_drop + 8'h01;
    endfunction

    // Single compare process: check outputs, log transfers, then advance the model
    // with the inputs the DUT will sample at the coming rising edge.
    always @(negedge clk_sys) begin
        bit mfire;
        if (!rst_n) begin
            m_busy = 1'b0; m_pend = 1'b0; m_pos = 0;
            m_seq  = 8'h00; m_drop = 8'h00; m_pval = '0;
            chk("rst_vld", tx_if.tx_vld, 0);
            chk("rst_busy", frame_busy, 0);
        end else begin
            chk("vld", tx_if.tx_vld, m_busy);
            chk("busy", frame_busy, m_busy);
            chk("drop", drop_cnt, m_drop);
            if (m_busy) chk("data", tx_if.tx_data, m_frame[m_pos]);
            if (tx_if.tx_vld && tx_if.tx_rdy) begin
                log_b.push_back(tx_if.tx_data);
                log_t.push_back(cyc);
            end
            mfire = m_busy && tx_if.tx_rdy;
            if (mfire && m_pos == 2 && m_frame[2] == 8'h00) zero_seq_frames++;
            if (!m_busy) begin
                if (para_upd) build(m_seq, sta_para_ave);
            end else if (mfire && m_pos == 5) begin
                m_seq = m_seq + 8'h01;
                if (para_upd) begin
                    if (m_pend) note_drop();
                    m_pend = 1'b0;
                    build(m_seq, sta_para_ave);
                end else if (m_pend) begin
                    m_pend = 1'b0;
                    build(m_seq, m_pval);
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                if (mfire) m_pos++;
                if (para_upd) begin
                    if (m_pend) note_drop();
                    m_pend = 1'b1;
                    m_pval = sta_para_ave;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        sta_para_ave = v;
        para_upd     = 1'b1;
        tick(1);
        para_upd     = 1'b0;
    endtask

    task automatic check_frame(input string nm, input int base, input logic [7:0] e [6],
                               input bit consecutive);
        chk({nm, "_len"}, (log_b.size() >= base + 6) ? 1 : 0, 1);
        if (log_b.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("%s_b%0d", nm, i), log_b[base+i], e[i]);
                if (consecutive && i > 0)
                    chk($sformatf("%s_gap%0d", nm, i), log_t[base+i] - log_t[base+i-1], 1);
            end
        end
    endtask

    initial begin
        int k;
        tx_if.tx_rdy = 1'b0;
        tick(3);
        chk("reset_data", tx_if.tx_data, 8'h00);
        chk("reset_vld", tx_if.tx_vld, 0);
        chk("reset_busy", frame_busy, 0);
        chk("reset_drop", drop_cnt, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // First frame, always ready: six consecutive bytes right after the strobe.
        tx_if.tx_rdy = 1'b1;
        log_b.delete(); log_t.delete();
        k = cyc;
        strobe(16'h1234);
        tick(10);
        check_frame("f1234", 0, '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h47}, 1'b1);
        if (log_t.size() > 0) chk("f1234_latency", log_t[0], k + 1);
        chk("f1234_idle_busy", frame_busy, 0);

        log_b.delete(); log_t.delete();
        strobe(16'hFFFE);
        tick(10);
        check_frame("fFFFE", 0, '{8'hA5, 8'h01, 8'h01, 8'hFF, 8'hFE, 8'hFF}, 1'b1);

        log_b.delete(); log_t.delete();
        strobe(16'h0000);
        tick(10);
        check_frame("fseq2", 0, '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03}, 1'b1);

        // Random stalls inside one frame.
        log_b.delete(); log_t.delete();
        strobe(16'hBEEF);
        for (int i = 0; i < 40; i++) begin
            tx_if.tx_rdy = $urandom_range(0, 1);
            tick(1);
        end
        tx_if.tx_rdy = 1'b1;
        tick(10);
        check_frame("fBEEF", 0, '{8'hA5, 8'h01, 8'h03, 8'hBE, 8'hEF, 8'hB1}, 1'b0);

        // Three updates during a stalled frame: last one wins, two drops, no gap.
        log_b.delete(); log_t.delete();
        tx_if.tx_rdy = 1'b0;
        strobe(16'h5555);
        tick(2);
        strobe(16'h0001);
        strobe(16'h0002);
        strobe(16'h0003);
        tx_if.tx_rdy = 1'b1;
        tick(20);
        check_frame("f5555", 0, '{8'hA5, 8'h01, 8'h04, 8'h55, 8'h55, 8'hAF}, 1'b1);
        check_frame("fpend", 6, '{8'hA5, 8'h01, 8'h05, 8'h00, 8'h03, 8'h09}, 1'b1);
        if (log_t.size() >= 7) chk("b2b_gap", log_t[6] - log_t[5], 1);
        chk("drop_two", drop_cnt, 8'h02);

        // Continuous updates: >300 back-to-back frames, seq wrap, drop saturation.
        tx_if.tx_rdy = 1'b1;
        para_upd = 1'b1;
        for (int i = 0; i < 1900; i++) begin
            sta_para_ave = 16'($urandom);
            tick(1);
        end
        para_upd = 1'b0;
        tick(10);
        chk("drop_sat", drop_cnt, 8'hFF);
        chk("seq_wrapped", (zero_seq_frames >= 2) ? 1 : 0, 1);

        // Random mix of strobes and stalls.
        for (int i = 0; i < 2000; i++) begin
            para_upd     = ($urandom_range(0, 5) == 0);
            sta_para_ave = 16'($urandom);
            tx_if.tx_rdy = $urandom_range(0, 1);
            tick(1);
        end
        para_upd = 1'b0;
        tx_if.tx_rdy = 1'b1;
        tick(20);
        chk("rand_idle", frame_busy, 0);

        // Asynchronous reset while byte3 is on the bus.
        strobe(16'h7777);
        tick(3);
        chk("pre_rst_byte3", tx_if.tx_data, 8'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", tx_if.tx_data, 8'h00);
        chk("arst_vld", tx_if.tx_vld, 0);
        chk("arst_busy", frame_busy, 0);
        chk("arst_drop", drop_cnt, 8'h00);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        log_b.delete(); log_t.delete();
        strobe(16'h0A0B);
        tick(10);
        check_frame("fpost", 0, '{8'hA5, 8'h01, 8'h00, 8'h0A, 8'h0B, 8'h16}, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/para_send.md
# para_send

Frame transmitter for the averaged time parameter. Snapshots `sta_para_ave` whenever the averager signals a fresh period result (`para_upd`). Sends each snapshot as a 6-byte checksummed frame over a byte-wide valid/ready stream toward the host link. Sits between the parameter block (`para_top`) and the byte-serial uplink; it is the reading end of the `sta_para_ave` interface.

## Interface
- `HEADER`, 8'hA5, frame start byte
- `PARA_ID`, 8'h01, parameter identifier byte
- `clk_sys`  input  1  system clock; all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `sta_para_ave`  input  16  averaged parameter, two's complement
- `para_upd`  input  1  one-cycle strobe: `sta_para_ave` holds a new result this cycle
- `tx_data`  output  8  frame byte
- `tx_vld`  output  1  `tx_data` valid
- `tx_rdy`  input  1  downstream accepts byte
- `frame_busy`  output  1  a frame is in progress
- `drop_cnt`  output  8  saturating count of overwritten (never sent) snapshots

## Operation
- Frame order:
  - byte0 `HEADER`
  - byte1 `PARA_ID`
  - byte2 `seq`
  - byte3 `ave[15:8]`
  - byte4 `ave[7:0]`
  - byte5 `chk`
- `chk` = (byte1+byte2+byte3+byte4) mod 256, accumulated as bytes are accepted. The header is excluded.
- `seq`: 8-bit counter, 0 after reset. Increments when byte5 is accepted; wraps FF→00.
- FSM states and transitions:
  - IDLE: on `para_upd`, capture `sta_para_ave` into the frame register, byte index = 0, go to SEND.
  - SEND: present byte[index]. On `tx_vld & tx_rdy`, index+1. When byte5 is accepted, go to IDLE, or directly start a new frame if `pend` is set.
- Pending slot:
  - `para_upd` during SEND (including the byte5 acceptance cycle) writes `sta_para_ave` into the pending register and sets `pend`.
  - If `pend` is already set, the old value is overwritten and `drop_cnt` increments, saturating at FF.
  - On frame end with `pend` set: the pending value moves to the frame register, `pend` clears, and the new frame starts.
- The current frame's payload never changes mid-frame.
- `frame_busy` = state is SEND.

## Timing
- Reset values: `tx_data`=00, `tx_vld`=0, `frame_busy`=0, `drop_cnt`=00, `seq`=00, `pend`=0, FSM=IDLE. Reset mid-frame aborts the frame immediately; no partial resumption.
- All outputs are registered.
- Latency: `para_upd` sampled at edge N in IDLE → `tx_vld`=1 with `tx_data`=`HEADER` in the cycle after edge N.
- Handshake rules:
  - Once `tx_vld` is asserted, it and `tx_data` hold stable until `tx_rdy`.
  - `tx_vld` never drops mid-frame.
  - `tx_rdy` high continuously → 6 consecutive transfer cycles per frame.
- Back-to-back frames: with `pend` set when byte5 is accepted at edge E, `HEADER` is presented in the cycle after E, so there is no idle gap. With `pend` clear, `tx_vld`=0 after E.
- `para_upd` coinciding with byte5 acceptance counts as pending and is sent back-to-back.
- `tx_rdy` while `tx_vld`=0 is ignored.

## Structure
- Shared `para_pkg` holds:
  - FSM state encoding (IDLE, SEND)
  - frame length constant (6)
  - byte index width (3)
  - default `HEADER`/`PARA_ID`
- One natural sub-module: `para_frame_mux`. It is a combinational byte select over index/header/id/seq/payload/chk. Everything else stays in the top.

## Test plan
- Reset, then `sta_para_ave`=16'h1234 with `para_upd`, `tx_rdy`=1 → bytes A5,01,00,12,34,47 on six consecutive cycles starting one cycle after the strobe; `frame_busy` low afterwards.
- Second update 16'hFFFE → A5,01,01,FF,FE,FF (chk = 01+01+FF+FE mod 256 = FF); `seq` then reads 02.
- `tx_rdy` toggled pseudo-randomly during a frame → `tx_data`/`tx_vld` stable while stalled; byte order and values unchanged.
- Three `para_upd` strobes during one frame (values 0001, 0002, 0003) → next frame carries 0003, back-to-back with no gap; `drop_cnt`=2.
- 300 frames sent back to back → `seq` wraps FF→00; 300 excess overwrites → `drop_cnt` saturates at FF.
- `rst_n` asserted at byte3 → outputs return to reset values asynchronously; next `para_upd` produces a full frame with `seq`=00.
